// File: rtl/spi_input_conditioner.sv
// Synchronises and glitch-filters the raw SPI pins (cs, sclk, mosi) and
// produces registered one-cycle edge pulses for the slave control FSM.
module spi_input_conditioner #(
   parameter int WAIT_TIME     = 3,
   parameter int COUNTER_WIDTH = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic cs_pin,
   input  logic sclk_pin,
   input  logic mosi_pin,
   output logic cs_cond,
   output logic sclk_cond,
   output logic mosi_cond,
   output logic cs_fall,
   output logic cs_rise,
   output logic sclk_pos,
   output logic sclk_neg,
   output logic mosi_pos,
   output logic mosi_neg
);

   // Channel order: [0]=cs, [1]=sclk, [2]=mosi; cs idles high.
   localparam logic [2:0] RST_LVL = 3'b001;
   localparam logic [COUNTER_WIDTH-1:0] LAST =
      COUNTER_WIDTH'(WAIT_TIME - 1);

   logic [2:0]               w_pins;
   logic [2:0]               r_sync0;
   logic [2:0]               r_sync1;
   logic [2:0]               r_cond;
   logic [2:0]               r_rise;
   logic [2:0]               r_fall;
   logic [COUNTER_WIDTH-1:0] r_cnt [3];

   assign w_pins = {mosi_pin, sclk_pin, cs_pin};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync0 <= RST_LVL;
         r_sync1 <= RST_LVL;
         r_cond  <= RST_LVL;
         r_rise  <= '0;
         r_fall  <= '0;
         for (int i = 0; i < 3; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync0 <= w_pins;
         r_sync1 <= r_sync0;
         for (int i = 0; i < 3; i++) begin
            r_rise[i] <= 1'b0;
            r_fall[i] <= 1'b0;
            if (r_sync1[i] == r_cond[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == LAST) begin
               // Level stable long enough: accept it and flag the edge.
               r_cond[i] <= r_sync1[i];
               r_cnt[i]  <= '0;
               r_rise[i] <= r_sync1[i];
               r_fall[i] <= ~r_sync1[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign cs_cond   = r_cond[0];
   assign sclk_cond = r_cond[1];
   assign mosi_cond = r_cond[2];

   assign cs_rise   = r_rise[0];
   assign cs_fall   = r_fall[0];
   assign sclk_pos  = r_rise[1];
   assign sclk_neg  = r_fall[1];
   assign mosi_pos  = r_rise[2];
   assign mosi_neg  = r_fall[2];

endmodule
